dmem_boot_sequencer: RTL and testbench

- Controls ownership of the data-memory write port: the host preload stream or the RISC-V pipeline.
- Sequences boot: holds the CPU in reset, streams host words into data memory, flushes the pipeline, then releases the CPU.
- A host reload request from RUN re-enters the load sequence.
- Sits between the host loader interface, riscv_cpu and data_mem.

---
 rtl/dmem_boot_sequencer.sv | 127 ++++++++++++
 tb/tb_dmem_boot_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_boot_sequencer.sv
// Data-memory write-port owner and CPU boot sequencer: host preload, pipeline flush, then RUN.
// Optional load checksum output is enabled by defining DMEM_LOAD_CKSUM_EN.
module dmem_boot_sequencer #(
  parameter int RELEASE_CYCLES = 5,
  parameter int MEM_BYTES      = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  input  logic        ld_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_funct3,
  output logic        cpu_rst,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_store,
  output logic        busy,
  output logic        load_err,
  output logic [15:0] word_cnt
`ifdef DMEM_LOAD_CKSUM_EN
  ,
  output logic [31:0] ld_cksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  localparam logic [32:0] MEM_LIMIT    = 33'(MEM_BYTES);
  localparam logic [7:0]  RELEASE_LOAD = 8'(RELEASE_CYCLES);
  localparam logic [2:0]  STORE_WORD   = 3'b010;

  state_t     state, state_next;
  logic [7:0] flush_cnt;
  logic       load_start;
  logic       accept;
  logic       good_word;

  assign accept    = ld_ready && ld_valid;
  assign good_word = (ld_addr[1:0] == 2'b00) && ({1'b0, ld_addr} < MEM_LIMIT);
  assign cpu_rst   = (state != RUN);
  assign busy      = (state != RUN);

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load_start = 1'b0;
    ld_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_store  = STORE_WORD;
    unique case (state)
      IDLE: begin
        if (ld_req) begin
          state_next = LOAD;
          load_start = 1'b1;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          if (good_word) begin
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_data;
          end
          if (ld_last) state_next = FLUSH;
        end
      end
      FLUSH: begin
        // <= 1 rather than == 1 so a zero count can never park the FSM here
        if (flush_cnt <= 8'd1) state_next = RUN;
      end
      RUN: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_store = cpu_funct3;
        if (ld_req) begin
          state_next = LOAD;
          load_start = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      word_cnt  <= '0;
      load_err  <= 1'b0;
      flush_cnt <= '0;
    end else begin
      state <= state_next;
      if (load_start) begin
        word_cnt <= '0;
        load_err <= 1'b0;
      end else if (accept) begin
        if (!good_word)                word_cnt <= word_cnt;
        else if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
        if (!good_word) load_err <= 1'b1;
      end
      if (accept && ld_last)                     flush_cnt <= RELEASE_LOAD;
      else if (state == FLUSH && flush_cnt != 0) flush_cnt <= flush_cnt - 8'd1;
    end
  end

`ifdef DMEM_LOAD_CKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      ld_cksum <= '0;
    else if (load_start)             ld_cksum <= '0;
    else if (accept && good_word)    ld_cksum <= ld_cksum + ld_data;
  end
`endif

endmodule

// File: tb/tb_dmem_boot_sequencer.sv
// Directed bench for dmem_boot_sequencer; memory writes are checked against a scoreboard queue.
module tb_dmem_boot_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid, ld_last, ld_req;
  logic        ld_ready;
  logic [31:0] ld_addr, ld_data;
  logic        cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic        cpu_rst, mem_we, busy, load_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_store;
  logic [15:0] word_cnt;
`ifdef DMEM_LOAD_CKSUM_EN
  logic [31:0] ld_cksum;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  store;
  } wr_t;

  wr_t sb[$];
  int  vectors     = 0;
  int  miscompares = 0;
  int  writes      = 0;

  dmem_boot_sequencer #(.RELEASE_CYCLES(5), .MEM_BYTES(1024)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .ld_req(ld_req),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
    .cpu_rst(cpu_rst), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_store(mem_store), .busy(busy), .load_err(load_err), .word_cnt(word_cnt)
`ifdef DMEM_LOAD_CKSUM_EN
    , .ld_cksum(ld_cksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every write on the memory port must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      writes++;
      if (sb.size() == 0) begin
        check("unexpected_write", {31'd0, mem_we}, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr",  mem_addr, e.addr);
        check("wr_data",  mem_wdata, e.data);
        check("wr_store", {29'd0, mem_store}, {29'd0, e.store});
      end
    end
  end

  task automatic pulse_req();
    @(posedge clk); #1 ld_req = 1'b1;
    @(posedge clk); #1 ld_req = 1'b0;
    @(negedge clk);
    check("load_entry_ready", {31'd0, ld_ready}, 32'd1);
    check("load_entry_cnt", {16'd0, word_cnt}, 32'd0);
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] d, input logic last, input logic good);
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_last = last;
    if (good) sb.push_back('{addr: a, data: d, store: 3'b010});
    @(negedge clk);
    check("ld_ready", {31'd0, ld_ready}, 32'd1);
  endtask

  task automatic idle_host();
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("run_reached", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_req = 1'b0;
    ld_addr = '0; ld_data = '0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = 3'b000;

    // Reset values
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_cpu_rst",  {31'd0, cpu_rst}, 32'd1);
    check("rst_busy",     {31'd0, busy}, 32'd1);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_mem_we",   {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_store",    {29'd0, mem_store}, 32'd2);
    check("rst_load_err", {31'd0, load_err}, 32'd0);
    check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);

    // Three-word boot load; cpu_rst must drop exactly 5 cycles after the last accept
    pulse_req();
    send_word(32'h0, 32'h11111111, 1'b0, 1'b1);
    send_word(32'h4, 32'h22222222, 1'b0, 1'b1);
    send_word(32'h8, 32'h33333333, 1'b1, 1'b1);
    idle_host();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("flush_cpu_rst_hi", {31'd0, cpu_rst}, 32'd1);
    end
    @(negedge clk);
    check("release_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("boot_busy", {31'd0, busy}, 32'd0);
    check("boot_word_cnt", {16'd0, word_cnt}, 32'd3);
    check("boot_writes", writes, 32'd3);
    check("boot_sb_drained", sb.size(), 32'd0);

    // RUN pass-through; host traffic is ignored
    @(posedge clk); #1;
    cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF; cpu_funct3 = 3'b000;
    ld_valid = 1'b1; ld_addr = 32'h40; ld_data = 32'h55555555;
    sb.push_back('{addr: 32'h10, data: 32'hDEADBEEF, store: 3'b000});
    @(negedge clk);
    check("run_ld_ready", {31'd0, ld_ready}, 32'd0);
    @(posedge clk); #1;
    cpu_we = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    check("run_word_cnt", {16'd0, word_cnt}, 32'd3);
    check("run_sb_drained", sb.size(), 32'd0);

    // Misaligned and out-of-range words: accepted, not written, error flagged
    pulse_req();
    send_word(32'h6,   32'h66666666, 1'b0, 1'b0);
    send_word(32'h400, 32'h77777777, 1'b0, 1'b0);
    send_word(32'hC,   32'h44444444, 1'b1, 1'b1);
    check("bad_load_err", {31'd0, load_err}, 32'd1);
    check("bad_word_cnt", {16'd0, word_cnt}, 32'd0);
    idle_host();
    wait_run();
    check("bad_final_cnt", {16'd0, word_cnt}, 32'd1);
    check("bad_sb_drained", sb.size(), 32'd0);

    // Reload while the CPU is writing: CPU path blocked from the next edge
    @(posedge clk); #1;
    cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678; cpu_funct3 = 3'b010;
    ld_req = 1'b1;
    sb.push_back('{addr: 32'h20, data: 32'h12345678, store: 3'b010});
    @(posedge clk); #1 ld_req = 1'b0;
    @(negedge clk);
    check("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("reload_blocked", {31'd0, mem_we}, 32'd0);
    check("reload_load_err", {31'd0, load_err}, 32'd0);
    cpu_we = 1'b0;
    send_word(32'h0, 32'hAAAA5555, 1'b1, 1'b1);
    idle_host();
    wait_run();
    check("reload_cnt", {16'd0, word_cnt}, 32'd1);
    check("reload_sb_drained", sb.size(), 32'd0);

    // Asynchronous reset in the middle of a four-word load
    pulse_req();
    send_word(32'h100, 32'h01010101, 1'b0, 1'b1);
    send_word(32'h104, 32'h02020202, 1'b0, 1'b1);
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_addr = 32'h108; ld_data = 32'h03030303; ld_last = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("arst_cpu_rst",  {31'd0, cpu_rst}, 32'd1);
    check("arst_word_cnt", {16'd0, word_cnt}, 32'd0);
    check("arst_load_err", {31'd0, load_err}, 32'd0);
    check("arst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("arst_mem_we",   {31'd0, mem_we}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_arst_idle_we", {31'd0, mem_we}, 32'd0);
      check("post_arst_busy", {31'd0, busy}, 32'd1);
    end
    ld_valid = 1'b0;
    check("arst_sb_drained", sb.size(), 32'd0);

`ifdef DMEM_LOAD_CKSUM_EN
    // Checksum wraps modulo 2^32 and skips rejected words
    pulse_req();
    check("cksum_cleared", ld_cksum, 32'd0);
    send_word(32'h200, 32'hFFFFFFFF, 1'b0, 1'b1);
    send_word(32'h205, 32'h00000007, 1'b0, 1'b0);
    send_word(32'h204, 32'h00000002, 1'b1, 1'b1);
    idle_host();
    @(negedge clk);
    check("cksum_wrap", ld_cksum, 32'h00000001);
    wait_run();
    check("cksum_sb_drained", sb.size(), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
